// File: rtl/pc_gen_if.sv
// Fetch-side bus between the PC generator and instruction memory.
// The generator presents an address (plus its sequential successor) with a
// valid flag; instruction memory answers with ready when it takes the address.
interface pc_gen_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] PCPlus4;
   logic             fetch_valid;
   logic             fetch_ready;

   modport master (
      output PC,
      output PCPlus4,
      output fetch_valid,
      input  fetch_ready
   );

   modport slave (
      input  PC,
      input  PCPlus4,
      input  fetch_valid,
      output fetch_ready
   );
endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator at the front of the core.
// Chooses the next PC among increment, PC-relative branch, register-indirect
// jump and trap vector. Stalled redirects wait in a one-entry buffer.
// A misaligned non-trap target halts fetch until a trap restarts it.
// The interface WIDTH must match this module's WIDTH.
module pc_gen #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
   parameter int               INC       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [1:0]       PCSrc,
   input  logic [WIDTH-1:0] ImmOp,
   input  logic [WIDTH-1:0] PCBranchBase,
   input  logic [WIDTH-1:0] RegBase,
   pc_gen_if.master         fetch,
   output logic             redirect_pending,
   output logic             misaligned,
   output logic             halted
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t           state;
   state_t           stateNext;
   logic [WIDTH-1:0] pcReg;
   logic [WIDTH-1:0] pcNext;
   logic             pendValid;
   logic             pendValidNext;
   logic [WIDTH-1:0] pendTarget;
   logic [WIDTH-1:0] pendTargetNext;
   logic             misReg;
   logic             misNext;

   logic [WIDTH-1:0] branchTarget;
   logic [WIDTH-1:0] jalrTarget;
   logic [WIDTH-1:0] reqTarget;
   logic             redirReq;
   logic             isTrap;
   logic             adv;

   // Candidate redirect targets; jalr drops bit 0 of the sum like RISC-V does.
   always_comb begin
      branchTarget = PCBranchBase + ImmOp;
      jalrTarget   = (RegBase + ImmOp) & ~WIDTH'(1);
      reqTarget    = (PCSrc == 2'b10) ? jalrTarget : branchTarget;
      redirReq     = (PCSrc == 2'b01) || (PCSrc == 2'b10);
      isTrap       = (PCSrc == 2'b11);
      adv          = fetch.fetch_valid && fetch.fetch_ready && !stall;
   end

   // Next-state and next-PC selection; trap beats the buffered redirect,
   // which beats a fresh redirect, which beats the sequential advance.
   always_comb begin
      stateNext      = state;
      pcNext         = pcReg;
      pendValidNext  = pendValid;
      pendTargetNext = pendTarget;
      misNext        = misReg;
      unique case (state)
         BOOT: begin
            stateNext = RUN;
         end
         RUN: begin
            if (isTrap) begin
               pcNext        = TRAP_VEC;
               pendValidNext = 1'b0;
            end else if (pendValid && !stall) begin
               pendValidNext = 1'b0;
               if (pendTarget[1:0] != 2'b00) begin
                  misNext   = 1'b1;
                  stateNext = HALT;
               end else begin
                  pcNext = pendTarget;
               end
            end else if (redirReq && !pendValid) begin
               if (stall) begin
                  pendValidNext  = 1'b1;
                  pendTargetNext = reqTarget;
               end else if (reqTarget[1:0] != 2'b00) begin
                  misNext   = 1'b1;
                  stateNext = HALT;
               end else begin
                  pcNext = reqTarget;
               end
            end else if (adv) begin
               pcNext = pcReg + WIDTH'(INC);
            end
         end
         HALT: begin
            if (isTrap) begin
               pcNext    = TRAP_VEC;
               misNext   = 1'b0;
               stateNext = RUN;
            end
         end
         default: begin
            stateNext = BOOT;
         end
      endcase
   end

   // State register; reset drops any buffered redirect immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= BOOT;
         pcReg      <= RESET_VEC;
         pendValid  <= 1'b0;
         pendTarget <= '0;
         misReg     <= 1'b0;
      end else begin
         state      <= stateNext;
         pcReg      <= pcNext;
         pendValid  <= pendValidNext;
         pendTarget <= pendTargetNext;
         misReg     <= misNext;
      end
   end

   // Outputs decoded from the held state.
   always_comb begin
      fetch.PC          = pcReg;
      fetch.PCPlus4     = pcReg + WIDTH'(INC);
      fetch.fetch_valid = (state == RUN);
      redirect_pending  = pendValid;
      misaligned        = misReg;
      halted            = (state == HALT);
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a directed vector table, a few hand-written
// reset sequences, then randomized traffic against a behavioural model.
module tb_pc_gen;

   logic        clk;
   logic        rst;
   logic        stall;
   logic [1:0]  PCSrc;
   logic [31:0] ImmOp;
   logic [31:0] PCBranchBase;
   logic [31:0] RegBase;
   logic        redirect_pending;
   logic        misaligned;
   logic        halted;

   int checks;
   int errors;

   pc_gen_if #(.WIDTH(32)) fif ();

   pc_gen #(
      .WIDTH(32),
      .RESET_VEC(32'h0),
      .TRAP_VEC(32'h0000_0100),
      .INC(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .PCSrc(PCSrc),
      .ImmOp(ImmOp),
      .PCBranchBase(PCBranchBase),
      .RegBase(RegBase),
      .fetch(fif.master),
      .redirect_pending(redirect_pending),
      .misaligned(misaligned),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] bb;
      logic [31:0] rb;
      logic        rdy;
      logic [31:0] ePc;
      logic        eFv;
      logic        ePend;
      logic        eMis;
      logic        eHalt;
   } vec_t;

   localparam int NVEC = 29;
   vec_t vecs[NVEC];

   // Behavioural model: mode 0 = boot, 1 = running, 2 = halted.
   int          mMode;
   logic [31:0] mPc;
   logic        mMis;
   logic [31:0] mPend[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic [31:0] ePc, input logic eFv,
                           input logic ePend, input logic eMis, input logic eHalt);
      checkOutput({tag, " PC"}, fif.PC, ePc);
      checkOutput({tag, " PCPlus4"}, fif.PCPlus4, ePc + 32'd4);
      checkOutput({tag, " fetch_valid"}, 32'(fif.fetch_valid), 32'(eFv));
      checkOutput({tag, " redirect_pending"}, 32'(redirect_pending), 32'(ePend));
      checkOutput({tag, " misaligned"}, 32'(misaligned), 32'(eMis));
      checkOutput({tag, " halted"}, 32'(halted), 32'(eHalt));
   endtask

   task automatic applyStimulus(input logic st, input logic [1:0] src, input logic [31:0] imm,
                                input logic [31:0] bb, input logic [31:0] rb, input logic rdy);
      @(negedge clk);
      stall           = st;
      PCSrc           = src;
      ImmOp           = imm;
      PCBranchBase    = bb;
      RegBase         = rb;
      fif.fetch_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   function automatic void modelReset();
      mMode = 0;
      mPc   = 32'h0;
      mMis  = 1'b0;
      mPend.delete();
   endfunction

   function automatic void modelLoad(input logic [31:0] t);
      if (t % 4 != 0) begin
         mMis  = 1'b1;
         mMode = 2;
         mPend.delete();
      end else begin
         mPc = t;
      end
   endfunction

   function automatic void modelEdge(input logic st, input logic [1:0] src, input logic [31:0] imm,
                                     input logic [31:0] bb, input logic [31:0] rb, input logic rdy);
      logic [31:0] t;
      logic [31:0] p;
      t = (src == 2'd2) ? ((rb + imm) & 32'hFFFF_FFFE) : (bb + imm);
      if (mMode == 0) begin
         mMode = 1;
      end else if (mMode == 2) begin
         if (src == 2'd3) begin
            mPc   = 32'h100;
            mMis  = 1'b0;
            mMode = 1;
         end
      end else if (src == 2'd3) begin
         mPc = 32'h100;
         mPend.delete();
      end else if (mPend.size() != 0 && !st) begin
         p = mPend.pop_front();
         modelLoad(p);
      end else if ((src == 2'd1 || src == 2'd2) && mPend.size() == 0) begin
         if (st) mPend.push_back(t);
         else    modelLoad(t);
      end else if (rdy && !st) begin
         mPc = mPc + 32'd4;
      end
   endfunction

   initial begin
      logic        st;
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] bb;
      logic [31:0] rb;
      logic        rdy;
      int          r;

      checks = 0;
      errors = 0;

      vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h4,         1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h8,         1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'hC,         1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h10,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h14,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b0, 32'h14,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h18,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h18,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 2'd0, 32'h0,         32'h0,         32'h0,   1'b0, 32'h18,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 2'd1, 32'hFFFF_FFF8, 32'h20,        32'h0,   1'b0, 32'h18,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 2'd2, 32'h3,         32'h0,         32'h41,  1'b1, 32'h44,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 2'd1, 32'h0,         32'h80,        32'h0,   1'b1, 32'h44,        1'b1, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 2'd1, 32'h0,         32'h90,        32'h0,   1'b1, 32'h44,        1'b1, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h80,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 2'd2, 32'h0,         32'h0,         32'h102, 1'b1, 32'h80,        1'b0, 1'b0, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h80,        1'b0, 1'b0, 1'b1, 1'b1};
      vecs[17] = '{1'b0, 2'd1, 32'h0,         32'h200,       32'h0,   1'b1, 32'h80,        1'b0, 1'b0, 1'b1, 1'b1};
      vecs[18] = '{1'b1, 2'd3, 32'h0,         32'h0,         32'h0,   1'b1, 32'h100,       1'b1, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 2'd1, 32'hC,         32'hFFFF_FFF0, 32'h0,   1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b1, 32'h4,         1'b1, 1'b0, 1'b0, 1'b0};
      vecs[22] = '{1'b1, 2'd3, 32'h0,         32'h0,         32'h0,   1'b0, 32'h100,       1'b1, 1'b0, 1'b0, 1'b0};
      vecs[23] = '{1'b1, 2'd2, 32'h1,         32'h0,         32'h300, 1'b1, 32'h100,       1'b1, 1'b1, 1'b0, 1'b0};
      vecs[24] = '{1'b1, 2'd3, 32'h0,         32'h0,         32'h0,   1'b1, 32'h100,       1'b1, 1'b0, 1'b0, 1'b0};
      vecs[25] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,   1'b0, 32'h100,       1'b1, 1'b0, 1'b0, 1'b0};
      vecs[26] = '{1'b1, 2'd1, 32'h0,         32'h202,       32'h0,   1'b1, 32'h100,       1'b1, 1'b1, 1'b0, 1'b0};
      vecs[27] = '{1'b0, 2'd2, 32'h0,         32'h0,         32'h400, 1'b1, 32'h100,       1'b0, 1'b0, 1'b1, 1'b1};
      vecs[28] = '{1'b0, 2'd3, 32'h0,         32'h0,         32'h0,   1'b1, 32'h100,       1'b1, 1'b0, 1'b0, 1'b0};

      // Hold reset with noisy inputs; outputs must sit at reset values.
      rst             = 1'b0;
      stall           = 1'b0;
      PCSrc           = 2'd3;
      ImmOp           = 32'h4;
      PCBranchBase    = 32'h40;
      RegBase         = 32'h40;
      fif.fetch_ready = 1'b1;
      #1;
      checkAll("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkAll("reset held", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Release away from an edge; cycle 0 is still boot.
      PCSrc = 2'd0;
      #1 rst = 1'b1;
      #1;
      checkAll("boot", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].st, vecs[i].src, vecs[i].imm, vecs[i].bb, vecs[i].rb, vecs[i].rdy);
         checkAll($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eFv, vecs[i].ePend,
                  vecs[i].eMis, vecs[i].eHalt);
      end

      // Reset in the middle of a stall with a redirect buffered.
      applyStimulus(1'b1, 2'd1, 32'h0, 32'h80, 32'h0, 1'b1);
      checkAll("prereset pend", 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      checkAll("async reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkAll("reboot", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic checked against the model.
      modelReset();
      for (int n = 0; n < 1500; n++) begin
         st  = ($urandom_range(0, 3) == 0);
         r   = $urandom_range(0, 99);
         src = (r < 55) ? 2'd0 : (r < 75) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
         rdy = ($urandom_range(0, 3) != 0);
         bb  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
         rb  = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
         imm = ($urandom_range(0, 11) == 0) ? 32'($urandom_range(1, 3)) : ($urandom & 32'hFFFF_FFFC);
         modelEdge(st, src, imm, bb, rb, rdy);
         applyStimulus(st, src, imm, bb, rb, rdy);
         checkAll($sformatf("rand%0d", n), mPc, (mMode == 1), (mPend.size() != 0), mMis, (mMode == 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator; successor of the single-width PC register with branch/increment select.
- Adds four-way next-PC select: increment, PC-relative branch, register-indirect jump, trap vector.
- Adds pipeline stall, a fetch valid/ready handshake with instruction memory, a one-entry pending-redirect buffer, and halt on misaligned targets.
- Sits at the front of the core, driving instruction-memory address and PCPlus4 into the IF/ID stage.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VEC, 0, PC value on reset.
- TRAP_VEC, 32'h0000_0100, trap handler address; a WIDTH-bit constant.
- INC, 4, sequential increment in bytes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- stall  input  1  hazard-unit stall; blocks increment and non-trap redirects.
- PCSrc  input  2  next-PC select: 00 increment, 01 branch, 10 jalr, 11 trap.
- ImmOp  input  WIDTH  immediate offset for branch/jalr.
- PCBranchBase  input  WIDTH  PC of the resolving branch instruction.
- RegBase  input  WIDTH  rs1 value for jalr.
- fetch_ready  input  1  instruction memory accepts PC this cycle.
- PC  output  WIDTH  current fetch address.
- PCPlus4  output  WIDTH  PC+INC, combinational, mod 2^WIDTH.
- fetch_valid  output  1  PC is a valid fetch request.
- redirect_pending  output  1  a buffered redirect is waiting.
- misaligned  output  1  sticky; set on a misaligned non-trap target.
- halted  output  1  block is in HALT.

Behaviour:
- Target computation, all mod 2^WIDTH:
  - branch = PCBranchBase+ImmOp
  - jalr = (RegBase+ImmOp) & ~1
  - trap = TRAP_VEC
- Misaligned target: target[1:0] != 0, checked only when a non-trap target is loaded into PC.
- Fetch advance: adv = fetch_valid & fetch_ready & !stall.
- States:
  - BOOT: entered on reset; fetch_valid=0, PC=RESET_VEC. Moves unconditionally to RUN on the first edge after rst deasserts. PCSrc is ignored in BOOT.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, PC held, halted=1.
- RUN priority per edge, highest first:
  1. PCSrc=11: PC<=TRAP_VEC, pending cleared. Applies regardless of stall and fetch_ready.
  2. pending & !stall: PC<=pending target, pending cleared. Any same-cycle non-trap PCSrc is ignored (wrong path).
  3. PCSrc in {01,10}, no pending, !stall: PC<=target.
  4. PCSrc in {01,10}, no pending, stall: target latched into pending, PC held.
  5. PCSrc in {01,10} while pending is already set: ignored; the older redirect wins.
  6. adv: PC<=PC+INC.
  7. Otherwise PC held.
- Redirects ignore fetch_ready. An unaccepted wrong-path fetch is simply dropped.
- Loading a misaligned target (cases 2 and 3): PC held, misaligned<=1, go to HALT, pending cleared.
- HALT: only PCSrc=11 exits, giving PC<=TRAP_VEC, misaligned<=0, state RUN. All other inputs are ignored.
- Reset values: PC=RESET_VEC, fetch_valid=0, redirect_pending=0, misaligned=0, halted=0, state BOOT, pending target 0.
- Reset asserted mid-operation takes effect immediately, without waiting for clk, and discards any pending redirect.
- Wrap: PC=2^WIDTH-INC, advancing, gives PC=0. No flag is raised.
- Latency: a redirect requested at edge N, unstalled, appears on PC after edge N. A stalled redirect appears one edge after the first cycle with stall=0.

Test Plan:
- Reset, then release rst with fetch_ready=1 -> cycle 0 after release: PC=0, fetch_valid=0. Then fetch_valid=1 and PC steps 0,4,8 on successive edges.
- PC=0x10, fetch_ready toggled 1,0,1 -> PC goes 0x14, holds at 0x14, then 0x18. With stall=1 PC holds regardless of fetch_ready.
- PCSrc=01, PCBranchBase=0x20, ImmOp=0xFFFF_FFF8 -> PC=0x18 next edge. PCSrc=10, RegBase=0x41, ImmOp=3 -> PC=0x44.
- stall=1 with PCSrc=01 target 0x80 -> redirect_pending=1, PC held. Next cycle PCSrc=01 target 0x90 while still stalled -> ignored. Drop stall -> PC=0x80, pending=0.
- PCSrc=10, RegBase=0x102, ImmOp=0 -> misaligned=1, halted=1, fetch_valid=0. Then PCSrc=11 -> PC=0x100, RUN, misaligned=0.
- PC=0xFFFF_FFFC advancing -> PC=0. Assert rst mid-stall with pending set -> PC=0 immediately, pending=0, state BOOT.
